rcc_eth_clk_mon: RTL and testbench

RCC_ETH_CLK_MON -- requirements
Module: rcc_eth_clk_mon

---
 rtl/rcc_eth_clk_mon.sv | 183 ++++++++++++++++++
 tb/tb_rcc_eth_clk_mon.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_eth_clk_mon.sv
// Ethernet kernel clock monitor: counts mon_clk rising edges over a window of
// reference clk cycles and flags a missing or off-frequency monitored clock.
module rcc_eth_clk_mon #(
    parameter int CNT_W   = 16,
    parameter int REC_WIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             mon_en,
    input  logic [CNT_W-1:0] win_len,
    input  logic [CNT_W-1:0] cnt_min,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic [2:0]       fail_thr,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_vld,
    output logic             clk_fail
);

    localparam int               GW       = (REC_WIN < 2) ? 1 : $clog2(REC_WIN + 1);
    localparam logic [GW-1:0]    GOOD_SAT = GW'(REC_WIN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        EVAL
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, hist_q;
    logic [1:0]       settle_q, settle_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [2:0]       bad_q, bad_d;
    logic [GW-1:0]    good_q, good_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic             meas_vld_q, meas_vld_d;
    logic [CNT_W-1:0] cfg_win_q, cfg_win_d;
    logic [CNT_W-1:0] cfg_min_q, cfg_min_d;
    logic [CNT_W-1:0] cfg_max_q, cfg_max_d;
    logic [2:0]       cfg_thr_q, cfg_thr_d;

    logic             edge_det;
    logic             win_last;
    logic             win_good;
    logic [CNT_W-1:0] w_eff;
    logic [2:0]       thr_eff;
    logic [2:0]       bad_nxt;
    logic [GW-1:0]    good_nxt;

    // mon_clk is asynchronous to clk; hist_q turns the synchronized level into a rising-edge strobe.
    // NOTE: every flop uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= mon_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~hist_q;
    assign w_eff    = (cfg_win_q == '0) ? ONE : cfg_win_q;
    assign thr_eff  = (cfg_thr_q == 3'd0) ? 3'd1 : cfg_thr_q;
    assign win_last = (win_cnt_q == w_eff - ONE);
    assign win_good = (edge_cnt_q >= cfg_min_q) && (edge_cnt_q <= cfg_max_q);
    assign bad_nxt  = (bad_q == 3'd7) ? bad_q : bad_q + 3'd1;
    assign good_nxt = (good_q >= GOOD_SAT) ? good_q : good_q + GW'(1);

    // NOTE: every next-state signal is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        win_cnt_d  = win_cnt_q;
        edge_cnt_d = edge_cnt_q;
        bad_d      = bad_q;
        good_d     = good_q;
        fail_d     = fail_q;
        meas_cnt_d = meas_cnt_q;
        meas_vld_d = 1'b0;
        cfg_win_d  = cfg_win_q;
        cfg_min_d  = cfg_min_q;
        cfg_max_d  = cfg_max_q;
        cfg_thr_d  = cfg_thr_q;

        if (!mon_en) begin
            state_d    = IDLE;
            settle_d   = 2'd0;
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            bad_d      = 3'd0;
            good_d     = '0;
            fail_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = SETTLE;
                    cfg_win_d = win_len;
                    cfg_min_d = cnt_min;
                    cfg_max_d = cnt_max;
                    cfg_thr_d = fail_thr;
                end
                SETTLE: begin
                    if (settle_q == 2'd3) begin
                        state_d  = MEASURE;
                        settle_d = 2'd0;
                    end else begin
                        settle_d = settle_q + 2'd1;
                    end
                end
                MEASURE: begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(edge_det);
                    if (win_last) begin
                        state_d   = EVAL;
                        win_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + ONE;
                    end
                end
                EVAL: begin
                    state_d    = MEASURE;
                    meas_cnt_d = edge_cnt_q;
                    meas_vld_d = 1'b1;
                    // An edge seen during EVAL belongs to the window that starts next.
                    edge_cnt_d = CNT_W'(edge_det);
                    if (win_good) begin
                        bad_d  = 3'd0;
                        good_d = good_nxt;
                        if (good_nxt >= GOOD_SAT) fail_d = 1'b0;
                    end else begin
                        good_d = '0;
                        bad_d  = bad_nxt;
                        if (bad_nxt >= thr_eff) fail_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= 2'd0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            bad_q      <= 3'd0;
            good_q     <= '0;
            fail_q     <= 1'b0;
            meas_cnt_q <= '0;
            meas_vld_q <= 1'b0;
            cfg_win_q  <= '0;
            cfg_min_q  <= '0;
            cfg_max_q  <= '0;
            cfg_thr_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            bad_q      <= bad_d;
            good_q     <= good_d;
            fail_q     <= fail_d;
            meas_cnt_q <= meas_cnt_d;
            meas_vld_q <= meas_vld_d;
            cfg_win_q  <= cfg_win_d;
            cfg_min_q  <= cfg_min_d;
            cfg_max_q  <= cfg_max_d;
            cfg_thr_q  <= cfg_thr_d;
        end
    end

    assign meas_cnt = meas_cnt_q;
    assign meas_vld = meas_vld_q;
    assign clk_fail = fail_q;

endmodule

// File: tb/tb_rcc_eth_clk_mon.sv
// Scoreboard bench for rcc_eth_clk_mon: a per-cycle mon_clk pattern drives the DUT and a
// window-level model predicts every meas_vld pulse, its count and the clk_fail level.
module tb_rcc_eth_clk_mon;

    localparam int CNT_W   = 16;
    localparam int REC_WIN = 2;
    localparam int MAXC    = 8192;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             mon_clk  = 1'b0;
    logic             mon_en   = 1'b0;
    logic [CNT_W-1:0] win_len  = '0;
    logic [CNT_W-1:0] cnt_min  = '0;
    logic [CNT_W-1:0] cnt_max  = '0;
    logic [2:0]       fail_thr = 3'd0;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_vld;
    logic             clk_fail;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;          // number of clk rising edges seen so far
    bit pat [MAXC];         // pat[t] = mon_clk level sampled at rising edge t

    typedef struct {
        int at;
        int cnt;
        bit fail;
    } exp_t;
    exp_t sb_q[$];

    // Window model state: enable edge, effective window, latched limits, streaks.
    int m_e, m_w, m_min, m_max, m_thr;
    int m_bad_run, m_good_run;
    bit m_fail;
    int last_ev, last_cnt;

    rcc_eth_clk_mon #(.CNT_W(CNT_W), .REC_WIN(REC_WIN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mon_clk  (mon_clk),
        .mon_en   (mon_en),
        .win_len  (win_len),
        .cnt_min  (cnt_min),
        .cnt_max  (cnt_max),
        .fail_thr (fail_thr),
        .meas_cnt (meas_cnt),
        .meas_vld (meas_vld),
        .clk_fail (clk_fail)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (cyc + 1 < MAXC) mon_clk = pat[cyc + 1];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && meas_vld) begin
            if (sb_q.size() == 0) begin
                check("meas_vld_unexpected", int'(meas_vld), 0);
            end else begin
                e = sb_q.pop_front();
                check("vld_cycle", cyc, e.at);
                check("meas_cnt", int'(meas_cnt), e.cnt);
                check("clk_fail", int'(clk_fail), int'(e.fail));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge at which window n is judged; the window period is W+1 cycles.
    function automatic int ev(input int n);
        return m_e + 5 + m_w + n * (m_w + 1);
    endfunction

    // A 0->1 step of mon_clk between samples u-3 and u-2 is credited at edge u.
    // Window 0 credits edges in its W measure cycles; later windows also own the
    // edge credited during the preceding judge cycle.
    function automatic int win_count(input int n);
        int lo = (n == 0) ? m_e + 5 : m_e + 4 + n * (m_w + 1);
        int hi = m_e + 4 + m_w + n * (m_w + 1);
        int c  = 0;
        for (int u = lo; u <= hi; u++)
            if (pat[u-2] && !pat[u-3]) c++;
        return c;
    endfunction

    task automatic start(input int win, input int mn, input int mx, input int thr);
        win_len  = CNT_W'(win);
        cnt_min  = CNT_W'(mn);
        cnt_max  = CNT_W'(mx);
        fail_thr = 3'(thr);
        mon_en   = 1'b1;
        m_e        = cyc + 1;
        m_w        = (win == 0) ? 1 : win;
        m_min      = mn;
        m_max      = mx;
        m_thr      = (thr == 0) ? 1 : thr;
        m_bad_run  = 0;
        m_good_run = 0;
        m_fail     = 1'b0;
    endtask

    // mode 0: held low, 1: square wave of the given period, 2: random levels
    task automatic fill(input int from, input int to, input int mode, input int period, input int ph);
        for (int c = from; c <= to && c < MAXC; c++) begin
            case (mode)
                0:       pat[c] = 1'b0;
                1:       pat[c] = ((c + ph) % period) < (period / 2);
                default: pat[c] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic push_windows(input int nwin);
        exp_t e;
        for (int n = 0; n < nwin; n++) begin
            int c = win_count(n);
            if (c >= m_min && c <= m_max) begin
                m_good_run++;
                m_bad_run = 0;
                if (m_good_run >= REC_WIN) m_fail = 1'b0;
            end else begin
                m_bad_run++;
                m_good_run = 0;
                if (m_bad_run >= m_thr) m_fail = 1'b1;
            end
            e.at   = ev(n);
            e.cnt  = c;
            e.fail = m_fail;
            sb_q.push_back(e);
            last_cnt = c;
        end
        last_ev = ev(nwin - 1);
    endtask

    // Configuration changes after the enable edge must not affect the running windows.
    task automatic scramble();
        win_len  = CNT_W'($urandom);
        cnt_min  = CNT_W'($urandom);
        cnt_max  = CNT_W'($urandom);
        fail_thr = 3'($urandom);
    endtask

    task automatic wait_done();
        tick(last_ev - cyc + 1);
        check("sb_drain", sb_q.size(), 0);
    endtask

    // Drop mon_en r cycles after the last judged window (1 <= r <= W).
    task automatic abort(input int r);
        tick(last_ev + r - cyc);
        mon_en = 1'b0;
        tick(1);
        check("abort_clk_fail", int'(clk_fail), 0);
        check("abort_meas_vld", int'(meas_vld), 0);
        check("abort_meas_cnt_hold", int'(meas_cnt), last_cnt);
        m_fail = 1'b0;
        tick(m_w + 4);
        check("abort_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        tick(3);
        check("rst_meas_vld", int'(meas_vld), 0);
        check("rst_clk_fail", int'(clk_fail), 0);
        check("rst_meas_cnt", int'(meas_cnt), 0);
        rst_n = 1'b1;
        tick(3);

        // clk/4 for three windows, stopped for two, then restarted; abort mid-window.
        start(100, 20, 30, 2);
        fill(cyc + 2, MAXC - 1, 1, 4, $urandom_range(0, 3));
        fill(ev(2), ev(4) - 4, 0, 1, 0);
        push_windows(9);
        tick(1);
        scramble();
        wait_done();
        abort(50);

        // Randomized configurations and patterns; the first re-enable uses W=10.
        for (int i = 0; i < 5; i++) begin
            int w    = (i == 0) ? 10 : $urandom_range(1, 40);
            int mode = (i % 3 == 2) ? 2 : 1;
            start(w, $urandom_range(0, 12), $urandom_range(0, 20), $urandom_range(0, 7));
            fill(cyc + 2, MAXC - 1, mode, $urandom_range(2, 9), $urandom_range(0, 8));
            push_windows($urandom_range(3, 8));
            tick(1);
            scramble();
            wait_done();
            abort($urandom_range(1, m_w));
        end

        // Zero window length and threshold with clk/2, both edge alignments.
        for (int ph = 0; ph < 2; ph++) begin
            start(0, 2, 3, 0);
            fill(cyc + 2, MAXC - 1, 1, 2, ph);
            push_windows(6);
            tick(1);
            scramble();
            wait_done();
            abort(1);
        end

        // Every window bad, threshold 1, then reset in the middle of a window.
        start(20, 5, 4, 1);
        fill(cyc + 2, MAXC - 1, 2, 2, 0);
        push_windows(2);
        tick(1);
        wait_done();
        check("pre_reset_clk_fail", int'(clk_fail), int'(m_fail));
        tick(7);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clk_fail", int'(clk_fail), 0);
        check("async_rst_meas_vld", int'(meas_vld), 0);
        check("async_rst_meas_cnt", int'(meas_cnt), 0);
        @(negedge clk);
        tick(3);
        check("held_rst_clk_fail", int'(clk_fail), 0);
        start(15, 0, 100, 3);
        rst_n = 1'b1;
        fill(cyc + 2, MAXC - 1, 1, 4, $urandom_range(0, 3));
        push_windows(3);
        wait_done();
        abort(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
